// File: rtl/seg_pkg.sv
// Shared constants and types for the seg_bcd_conv display-formatting stage.
package seg_pkg;

    localparam logic [1:0] MODE_HEX  = 2'd0;
    localparam logic [1:0] MODE_UDEC = 2'd1;
    localparam logic [1:0] MODE_SDEC = 2'd2;

    localparam int unsigned DIGITS_DEF = 8;
    localparam int unsigned BCD_W_DEF  = 40;

    localparam logic [4*DIGITS_DEF-1:0] SAT_DATA = {DIGITS_DEF{4'h9}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StFin  = 2'd2
    } state_e;

    // Mode 3 is reserved and falls back to hex along with MODE_HEX.
    function automatic logic is_dec(input logic [1:0] mode);
        return (mode == MODE_UDEC) || (mode == MODE_SDEC);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/seg_bcd_conv.sv
// Converts a 32-bit value to hex or (signed) decimal BCD nibbles for scan_seg,
// using one double-dabble iteration per clock; outputs hold between conversions.
module seg_bcd_conv
    import seg_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned BCD_W  = BCD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       in_value,
    input  logic [1:0]            in_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   seg_data,
    output logic                  seg_neg,
    output logic                  seg_ovf,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_e                r_state, w_state_next;
    logic [1:0]            r_mode, w_mode_next;
    logic [IN_W-1:0]       r_operand, w_operand_next;
    logic [BCD_W-1:0]      r_bcd, w_bcd_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                  r_neg, w_neg_next;
    logic                  r_zero, w_zero_next;
    logic [4*DIGITS-1:0]   r_seg_data, w_seg_data_next;
    logic                  r_seg_neg, w_seg_neg_next;
    logic                  r_seg_ovf, w_seg_ovf_next;
    logic                  r_done, w_done_next;

    logic [IN_W-1:0]       w_mag;
    logic [BCD_W-1:0]      w_bcd_adj;
    logic [BCD_W+IN_W-1:0] w_shift;

    for (genvar g = 0; g < BCD_W / 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    assign w_shift = {w_bcd_adj, r_operand} << 1;
    assign w_mag   = in_value[IN_W-1] ? (~in_value + IN_W'(1)) : in_value;

    always_comb begin
        w_state_next    = r_state;
        w_mode_next     = r_mode;
        w_operand_next  = r_operand;
        w_bcd_next      = r_bcd;
        w_cnt_next      = r_cnt;
        w_neg_next      = r_neg;
        w_zero_next     = r_zero;
        w_seg_data_next = r_seg_data;
        w_seg_neg_next  = r_seg_neg;
        w_seg_ovf_next  = r_seg_ovf;
        w_done_next     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_mode_next = in_mode;
                    w_bcd_next  = '0;
                    w_cnt_next  = '0;
                    w_zero_next = (in_value == '0);
                    if (in_mode == MODE_SDEC) begin
                        w_operand_next = w_mag;
                        w_neg_next     = in_value[IN_W-1];
                    end else begin
                        w_operand_next = in_value;
                        w_neg_next     = 1'b0;
                    end
                    w_state_next = is_dec(in_mode) ? StConv : StFin;
                end
            end
            StConv: begin
                w_bcd_next     = w_shift[BCD_W+IN_W-1:IN_W];
                w_operand_next = w_shift[IN_W-1:0];
                w_cnt_next     = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = StFin;
                end
            end
            StFin: begin
                if (!is_dec(r_mode)) begin
                    w_seg_data_next = r_operand[4*DIGITS-1:0];
                    w_seg_ovf_next  = 1'b0;
                end else if (r_bcd[BCD_W-1:4*DIGITS] != '0) begin
                    w_seg_data_next = SAT_DATA;
                    w_seg_ovf_next  = 1'b1;
                end else begin
                    w_seg_data_next = r_bcd[4*DIGITS-1:0];
                    w_seg_ovf_next  = 1'b0;
                end
                // A zero magnitude never shows a minus sign.
                w_seg_neg_next = r_neg & ~r_zero;
                w_done_next    = 1'b1;
                w_state_next   = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_mode     <= MODE_HEX;
            r_operand  <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_zero     <= 1'b0;
            r_seg_data <= '0;
            r_seg_neg  <= 1'b0;
            r_seg_ovf  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode     <= w_mode_next;
            r_operand  <= w_operand_next;
            r_bcd      <= w_bcd_next;
            r_cnt      <= w_cnt_next;
            r_neg      <= w_neg_next;
            r_zero     <= w_zero_next;
            r_seg_data <= w_seg_data_next;
            r_seg_neg  <= w_seg_neg_next;
            r_seg_ovf  <= w_seg_ovf_next;
            r_done     <= w_done_next;
        end
    end

    assign in_ready = (r_state == StIdle);
    assign busy     = (r_state != StIdle);
    assign seg_data = r_seg_data;
    assign seg_neg  = r_seg_neg;
    assign seg_ovf  = r_seg_ovf;
    assign done     = r_done;

endmodule

// File: tb/tb_seg_bcd_conv.sv
// Directed self-checking bench for seg_bcd_conv: hex, unsigned and signed decimal,
// saturation, mid-conversion reset and request handling while busy.
module tb_seg_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_value;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] seg_data;
    logic        seg_neg;
    logic        seg_ovf;
    logic        done;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_bcd_conv dut (
        .clk      (clk),
        .rst      (rst),
        .in_value (in_value),
        .in_mode  (in_mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seg_data (seg_data),
        .seg_neg  (seg_neg),
        .seg_ovf  (seg_ovf),
        .done     (done),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is accepted at the following posedge (E0).
    task automatic send(input logic [31:0] v, input logic [1:0] m);
        in_value = v;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat = index k of the posedge E_k at which done rose (100 means timeout).
    task automatic wait_done(output int lat, output bit ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        while (!done && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] v, input logic [1:0] m,
                       input logic [31:0] exp_data, input logic exp_neg,
                       input logic exp_ovf, input int exp_lat);
        int lat;
        bit ready_seen;
        send(v, m);
        wait_done(lat, ready_seen);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".data"}, seg_data, exp_data);
        check({tag, ".neg"}, {31'd0, seg_neg}, {31'd0, exp_neg});
        check({tag, ".ovf"}, {31'd0, seg_ovf}, {31'd0, exp_ovf});
        check({tag, ".ready_low"}, {31'd0, ready_seen}, 32'd0);
        check({tag, ".idle"}, {30'd0, in_ready, busy}, 32'd2);
        @(negedge clk);
        check({tag, ".done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, ".hold"}, seg_data, exp_data);
    endtask

    initial begin
        int lat;
        bit ready_seen;
        bit done_seen;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        in_mode  = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.data", seg_data, 32'h0);
        check("reset.flags", {27'd0, seg_neg, seg_ovf, done, busy, in_ready}, 32'h1);

        run("hex4", 32'h0000_0004, 2'd0, 32'h0000_0004, 1'b0, 1'b0, 1);
        run("udec12345678", 32'h00BC_614E, 2'd1, 32'h1234_5678, 1'b0, 1'b0, 33);
        run("udec1e8", 32'h05F5_E100, 2'd1, 32'h9999_9999, 1'b0, 1'b1, 33);
        run("udec0", 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0, 1'b0, 33);
        run("sdec-42", 32'hFFFF_FFD6, 2'd2, 32'h0000_0042, 1'b1, 1'b0, 33);
        run("hexneg", 32'hFFFF_FFD6, 2'd0, 32'hFFFF_FFD6, 1'b0, 1'b0, 1);
        run("rsvd", 32'hDEAD_BEEF, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        run("sdec99999999", 32'h05F5_E0FF, 2'd2, 32'h9999_9999, 1'b0, 1'b0, 33);
        run("sdec0", 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0, 1'b0, 33);
        run("sdecmin", 32'h8000_0000, 2'd2, 32'h9999_9999, 1'b1, 1'b1, 33);

        // Reset at E10 of a decimal conversion aborts it.
        send(32'h0098_967F, 2'd1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.data", seg_data, 32'h0);
        check("abort.flags", {27'd0, seg_neg, seg_ovf, done, busy, in_ready}, 32'h1);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("abort.nodone", {31'd0, done_seen}, 32'd0);
        run("abort.hex", 32'h00AB_CDEF, 2'd0, 32'h00AB_CDEF, 1'b0, 1'b0, 1);

        // Valid held high with junk during CONV; next accept lands after the FIN edge.
        in_value = 32'h0000_0315;
        in_mode  = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 100) begin
            in_value = $urandom;
            @(negedge clk);
            lat++;
        end
        check("hold.lat", lat, 33);
        check("hold.data", seg_data, 32'h0000_0789);
        in_value = 32'h0000_0020;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b.accepted", {31'd0, busy}, 32'd1);
        wait_done(lat, ready_seen);
        check("b2b.lat", lat, 33);
        check("b2b.data", seg_data, 32'h0000_0032);
        check("b2b.flags", {30'd0, seg_neg, seg_ovf}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_bcd_conv.md
Name: seg_bcd_conv

Overview:
Display-formatting stage directly upstream of scan_seg; produces the packed 8-nibble seg_data word that scan_seg multiplexes onto the 7-segment digits.
- Accepts a 32-bit value from the CPU/MMIO side over a valid/ready handshake.
- Converts it to hex nibbles (passthrough), unsigned decimal BCD, or signed decimal BCD (magnitude plus sign flag).
- Decimal conversion is a sequential double-dabble, one iteration per clock.
- Holds the last result stable between conversions so the display never shows partial results.

Parameters:
IN_W, 32, input value width; also the double-dabble iteration count.
DIGITS, 8, output BCD digits; seg_data width = 4*DIGITS. Only 8 is supported in this revision.
BCD_W, 40, internal BCD accumulator width (10 digits, enough for 2^32-1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_value  in  IN_W  value to display
in_mode  in  2  0=hex, 1=unsigned decimal, 2=signed decimal, 3=reserved (treated as hex)
in_valid  in  1  request; accepted when in_valid && in_ready at a rising edge
in_ready  out  1  high only in IDLE
seg_data  out  4*DIGITS  packed nibbles to scan_seg; nibble 0 = rightmost digit
seg_neg  out  1  result is negative (signed mode); consumer lights the minus indicator
seg_ovf  out  1  magnitude exceeded 10^DIGITS-1; seg_data saturated
done  out  1  one-cycle pulse when seg_data/seg_neg/seg_ovf update
busy  out  1  conversion in progress (state != IDLE)

Behaviour:
- Reset, synchronous, active-high, checked at the clock edge: state=IDLE; seg_data=0, seg_neg=0, seg_ovf=0, done=0, busy=0, in_ready=1; iteration counter and shift registers cleared.
- Reset asserted mid-conversion aborts it: no done pulse, outputs go to reset values.
- States: IDLE, CONV, FIN.
- IDLE, on accept at edge E0:
  - Latch in_mode and operand.
  - Signed mode: operand = two's-complement magnitude; latch neg = in_value[31]. Unsigned and hex modes: neg = 0.
  - Hex or reserved mode: go to FIN.
  - Decimal modes: go to CONV with cnt=0 and bcd=0.
- CONV: each edge applies add-3 to every BCD digit >= 5, then shifts {bcd, operand} left by 1 and increments cnt. After the 32nd iteration (edge E32), go to FIN.
- FIN, at the next edge:
  - Hex: seg_data = operand, seg_ovf = 0.
  - Decimal: if BCD digits 9..8 are nonzero, seg_data = 32'h9999_9999 and seg_ovf = 1; else seg_data = bcd[31:0] and seg_ovf = 0.
  - seg_neg = neg, except a magnitude of 0 forces seg_neg = 0.
  - done = 1 for exactly the following cycle; state returns to IDLE.
- Latency: hex mode, outputs update at E1 (done high in cycle E1..E2). Decimal modes, outputs update at E33.
- in_ready = 1 only in IDLE. Requests are not queued; in_valid during CONV/FIN is ignored.
- Back-to-back: a new request can be accepted at the edge after the FIN update edge.
- Signed 0x8000_0000: magnitude 2147483648 overflows, giving 0x99999999 with seg_ovf=1 and seg_neg=1.
- seg_data, seg_neg and seg_ovf are registered and change only at the FIN update edge or on reset.

Decomposition:
- seg_pkg holds:
  - mode constants MODE_HEX=2'd0, MODE_UDEC=2'd1, MODE_SDEC=2'd2
  - state encoding for IDLE/CONV/FIN
  - DIGITS and BCD_W defaults
  - the saturation constant {DIGITS{4'h9}}
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if-≥5, instantiated BCD_W/4 times via generate.

Test Plan:
1. Hex 0x0000_0004: rst pulse, then valid with mode 0 -> at E1 seg_data=0x00000004, done high one cycle, seg_ovf=0, seg_neg=0.
2. Unsigned 12345678 (0x00BC614E), mode 1 -> busy for 33 cycles; at E33 seg_data=0x12345678, done pulse; in_ready low throughout.
3. Unsigned 100000000 (0x05F5E100) -> seg_data=0x99999999, seg_ovf=1. Follow with 0 -> seg_data=0x00000000, seg_ovf=0.
4. Signed -42 (0xFFFFFFD6), mode 2 -> seg_data=0x00000042, seg_neg=1. Signed 0x80000000 -> 0x99999999, seg_neg=1, seg_ovf=1.
5. Assert rst for one cycle at E10 of a decimal conversion -> no done pulse; outputs return to 0; in_ready=1 next cycle. A new hex request then completes normally.
6. Hold in_valid high with changing in_value during CONV -> only the accepted value appears. The second request is accepted at the edge after the FIN update edge.
